seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider: the inverse datapath to the ripple-carry adder, which it reuses in subtract mode.
- Accepts a dividend/divisor pair on a start pulse and produces one quotient bit per clock, MSB first.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- Sits beside the adder in the ALU as the DIV/MOD execution unit.

---
 rtl/seq_divider_pkg.sv | 10 +
 rtl/seq_divider_adder.sv | 23 ++
 rtl/seq_divider.sv | 108 ++++++++++
 tb/tb_seq_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_adder.sv
// Ripple-carry adder; the divider drives it as a subtractor (b inverted, c_in=1).
module seq_divider_adder #(
  parameter int size = 9
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            c_in,
  output logic [size-1:0] sum,
  output logic            c_out
);

  logic [size:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < size; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[size];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first,
// with a one-cycle done pulse and a divide-by-zero shortcut path.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;

  div_state_t      state, state_nxt;
  logic [size-1:0] q, dvsr, dvnd;
  logic [size:0]   r, rs, diff, r_nxt;
  logic [CW-1:0]   cnt;
  logic            no_borrow;
  logic [size-1:0] q_shift;
  logic            r_top_unused;

  // Partial remainder stays below the divisor, so r[size] is always 0 here.
  assign r_top_unused = r[size];
  assign rs           = {r[size-1:0], q[size-1]};

  seq_divider_adder #(.size(size + 1)) u_sub (
    .a    (rs),
    .b    (~{1'b0, dvsr}),
    .c_in (1'b1),
    .sum  (diff),
    .c_out(no_borrow)
  );

  assign q_shift = {q[size-2:0], no_borrow};
  assign r_nxt   = no_borrow ? diff : rs;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? ZERO : CALC;
      CALC:    if (cnt == '0) state_nxt = IDLE;
      ZERO:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      r           <= '0;
      dvsr        <= '0;
      dvnd        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvnd        <= dividend;
          dvsr        <= divisor;
          q           <= dividend;
          r           <= '0;
          cnt         <= CW'(size - 1);
          div_by_zero <= 1'b0;
          busy        <= 1'b1;
        end
        CALC: begin
          q <= q_shift;
          r <= r_nxt;
          if (cnt == '0) begin
            quotient  <= q_shift;
            remainder <= r_nxt[size-1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ZERO: begin
          quotient    <= '1;
          remainder   <= dvnd;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench: driver pushes expected results from an arithmetic model,
// monitor pops and compares on every done pulse.
module tb_seq_divider;

  localparam int SZ = 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [SZ-1:0] dividend, divisor;
  logic          busy, done, div_by_zero;
  logic [SZ-1:0] quotient, remainder;

  seq_divider #(.size(SZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SZ-1:0] q;
    logic [SZ-1:0] r;
    logic          z;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [SZ-1:0] a, input logic [SZ-1:0] b, input int acc);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.z = 1'b1; e.lat = 1;
    end else begin
      e.q = SZ'(int'(a) / int'(b));
      e.r = SZ'(int'(a) % int'(b));
      e.z = 1'b0; e.lat = SZ;
    end
    e.acc = acc;
    return e;
  endfunction

  // Waits (bounded) for an idle cycle, presents start for one edge.
  task automatic issue(input logic [SZ-1:0] a, input logic [SZ-1:0] b,
                       input bit track, output bit was_done);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 0);
    was_done = done;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (track) sb.push_back(model(a, b, cyc));
  endtask

  // Monitor
  logic          prev_done = 1'b0;
  logic [SZ-1:0] last_q, last_r;
  logic          last_z;

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (prev_done) chk("done_width", 32'(prev_done), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", 32'(quotient), 32'(e.q));
          chk("remainder", 32'(remainder), 32'(e.r));
          chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          last_q = e.q; last_r = e.r; last_z = e.z;
        end
      end else if (prev_done) begin
        chk("hold_quotient", 32'(quotient), 32'(last_q));
        chk("hold_remainder", 32'(remainder), 32'(last_r));
        if (!busy) chk("hold_dbz", 32'(div_by_zero), 32'(last_z));
      end
    end
    prev_done = done;
  end

  initial begin
    bit wd;
    int n;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_q", 32'(quotient), 0);
    chk("rst_r", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // 200/7 with busy-length check
    issue(8'd200, 8'd7, 1, wd);
    n = 1;
    while (busy && n < 40) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("busy_cycles", 32'(n), 8);

    issue(8'd255, 8'd1, 1, wd);
    issue(8'd5,   8'd9, 1, wd);
    issue(8'd0,   8'd3, 1, wd);
    issue(8'd17,  8'd0, 1, wd);
    issue(8'd10,  8'd3, 1, wd);
    chk("dbz_cleared_on_accept", 32'(div_by_zero), 0);

    // Reset in the middle of a division
    issue(8'd100, 8'd9, 0, wd);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_q", 32'(quotient), 0);
    chk("abort_r", 32'(remainder), 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);
    issue(8'd100, 8'd9, 1, wd);

    // start while busy is ignored
    issue(8'd50, 8'd5, 1, wd);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd99; divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;

    // start in the done cycle is accepted
    issue(8'd99, 8'd2, 1, wd);
    chk("accept_in_done_cycle", 32'(wd), 1);

    for (int i = 0; i < 1000; i++) begin
      logic [SZ-1:0] a, b;
      a = SZ'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 :
          ($urandom_range(0, 1) == 0) ? SZ'($urandom_range(1, 15)) : SZ'($urandom);
      issue(a, b, 1, wd);
    end

    n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
